// File: rtl/ctl_vote.sv
// ---------------------------------------------------------------------------
// ctl_vote
// Pipeline power/enable controller. Votes N_VAD voice-activity channels,
// debounces the vote over VAD_HOLD_CYCLES consecutive cycles, then enables
// the PDM clock / feature pipeline until the classifier signals completion
// (falling edge of wake_valid_i) or the max-on watchdog expires. After
// turn-off the block sits in TIMEOUT for TIMEOUT_CYCLES before it can re-arm.
//
// Optional feature macro: CTL_VOTE_STATS_EN
//   defined     -> saturating wake / watchdog statistics counters
//   not defined -> no counter flops, wake_cnt_o / wdog_cnt_o tied to 0
//
// Ports
//   clk_i         in   1       system clock, all logic on posedge
//   rst_i         in   1       synchronous active-high reset
//   vad_i         in   N_VAD   voice activity per channel
//   wake_valid_i  in   1       inference valid; falling edge = inference done
//   en_o          out  1       pipeline/PDM enable (state == ON)
//   busy_o        out  1       high whenever state != IDLE
//   state_o       out  2       IDLE=0, ARM=1, ON=2, TIMEOUT=3
//   watchdog_o    out  1       one-cycle pulse when watchdog forces turn-off
//   wake_cnt_o    out  STAT_W  number of ON entries (saturating)
//   wdog_cnt_o    out  STAT_W  number of watchdog expiries (saturating)
// ---------------------------------------------------------------------------
module ctl_vote #(
   parameter int N_VAD           = 1,
   parameter int VAD_VOTES       = 1,
   parameter int VAD_HOLD_CYCLES = 2,
   parameter int ON_MAX_CYCLES   = 1000,
   parameter int TIMEOUT_CYCLES  = 5,
   parameter int STAT_W          = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [N_VAD-1:0]  vad_i,
   input  logic              wake_valid_i,
   output logic              en_o,
   output logic              busy_o,
   output logic [1:0]        state_o,
   output logic              watchdog_o,
   output logic [STAT_W-1:0] wake_cnt_o,
   output logic [STAT_W-1:0] wdog_cnt_o
);

   // The one shared counter must hold the largest terminal count of any state.
   localparam int MAX_A = (VAD_HOLD_CYCLES > ON_MAX_CYCLES) ? VAD_HOLD_CYCLES : ON_MAX_CYCLES;
   localparam int MAX_C = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
   localparam int CW    = (MAX_C < 1) ? 1 : $clog2(MAX_C + 1);

   localparam logic [CW-1:0] HOLD_LAST = CW'(VAD_HOLD_CYCLES - 1);
   localparam logic [CW-1:0] ON_LAST   = CW'((ON_MAX_CYCLES == 0) ? 0 : ON_MAX_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      ON      = 2'd2,
      TIMEOUT = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   counter_q, counter_d;
   logic            wakeValid_q;
   logic            watchdog_q, watchdog_d;
   logic [31:0]     voteCount;
   logic            vote;
   logic            fall;

   // Count how many channels report voice activity this cycle; the vote
   // passes once at least VAD_VOTES of them agree.
   always_comb begin
      voteCount = '0;
      for (int i = 0; i < N_VAD; i++) begin
         voteCount = voteCount + 32'(vad_i[i]);
      end
   end

   assign vote = (voteCount >= 32'(VAD_VOTES));
   assign fall = wakeValid_q & ~wake_valid_i;

   // State, shared counter, registered wake_valid for edge detection and the
   // registered watchdog pulse.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         counter_q   <= '0;
         wakeValid_q <= 1'b0;
         watchdog_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         counter_q   <= counter_d;
         wakeValid_q <= wake_valid_i;
         watchdog_q  <= watchdog_d;
      end
   end

   // Next-state logic. A fall outside ON is simply not looked at, so it
   // cannot be remembered into a later ON period. In ON the fall check comes
   // before the watchdog check so a same-cycle collision is treated as a
   // normal completion and no watchdog pulse is raised. With the watchdog
   // disabled the counter saturates instead of wrapping.
   always_comb begin
      state_d    = state_q;
      counter_d  = counter_q;
      watchdog_d = 1'b0;
      case (state_q)
         IDLE: begin
            counter_d = '0;
            if (vote) begin
               if (VAD_HOLD_CYCLES == 1) begin
                  state_d = ON;
               end else begin
                  state_d   = ARM;
                  counter_d = CW'(1);
               end
            end
         end
         ARM: begin
            if (!vote) begin
               state_d   = IDLE;
               counter_d = '0;
            end else if (counter_q == HOLD_LAST) begin
               state_d   = ON;
               counter_d = '0;
            end else begin
               counter_d = counter_q + CW'(1);
            end
         end
         ON: begin
            if (fall) begin
               state_d   = TIMEOUT;
               counter_d = '0;
            end else if ((ON_MAX_CYCLES != 0) && (counter_q == ON_LAST)) begin
               state_d    = TIMEOUT;
               counter_d  = '0;
               watchdog_d = 1'b1;
            end else if (counter_q != '1) begin
               counter_d = counter_q + CW'(1);
            end
         end
         TIMEOUT: begin
            if (counter_q == TO_LAST) begin
               state_d   = IDLE;
               counter_d = '0;
            end else begin
               counter_d = counter_q + CW'(1);
            end
         end
         default: begin
            state_d   = IDLE;
            counter_d = '0;
         end
      endcase
   end

   assign en_o       = (state_q == ON);
   assign busy_o     = (state_q != IDLE);
   assign state_o    = state_q;
   assign watchdog_o = watchdog_q;

`ifdef CTL_VOTE_STATS_EN
   logic [STAT_W-1:0] wakeCnt_q;
   logic [STAT_W-1:0] wdogCnt_q;
   logic              wakeEvent;

   assign wakeEvent = (state_d == ON) && (state_q != ON);

   // Statistics update on the same edge as the event they record and stick
   // at all-ones; only reset clears them.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wakeCnt_q <= '0;
         wdogCnt_q <= '0;
      end else begin
         if (wakeEvent && (wakeCnt_q != '1)) begin
            wakeCnt_q <= wakeCnt_q + STAT_W'(1);
         end
         if (watchdog_d && (wdogCnt_q != '1)) begin
            wdogCnt_q <= wdogCnt_q + STAT_W'(1);
         end
      end
   end

   assign wake_cnt_o = wakeCnt_q;
   assign wdog_cnt_o = wdogCnt_q;
`else
   assign wake_cnt_o = '0;
   assign wdog_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ctl_vote.sv
// ---------------------------------------------------------------------------
// tb_ctl_vote
// Self-checking bench for ctl_vote. Two instances: A (4 channels, 3 votes,
// hold 2, watchdog 8, timeout 5, 2-bit stats) and B (1 channel, no debounce,
// watchdog disabled, timeout 1). A behavioural model tracks vote streaks and
// time spent enabled / cooling down and is compared to both DUTs every cycle;
// directed sequences with literal expectations pin the model.
// ---------------------------------------------------------------------------
module tb_ctl_vote;

   localparam int A_N = 4, A_VOTES = 3, A_HOLD = 2, A_ONMAX = 8, A_TMO = 5, A_SW = 2;
   localparam int B_N = 1, B_VOTES = 1, B_HOLD = 1, B_ONMAX = 0, B_TMO = 1, B_SW = 4;

   localparam int WAITING = 0, ENABLED = 1, COOLING = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [A_N-1:0]    vadA = '0;
   logic              wvA = 1'b0;
   logic [B_N-1:0]    vadB = '0;
   logic              wvB = 1'b0;

   logic              enA, busyA, wdA, enB, busyB, wdB;
   logic [1:0]        stateA, stateB;
   logic [A_SW-1:0]   wakeCntA, wdogCntA;
   logic [B_SW-1:0]   wakeCntB, wdogCntB;

   int assertions = 0;
   int failures   = 0;
   bit modelReady = 1'b0;

   int mMode[2], mStreak[2], mOnAge[2], mToAge[2], mWake[2], mWdog[2];
   bit mPulse[2], mPrevWv[2];

   ctl_vote #(.N_VAD(A_N), .VAD_VOTES(A_VOTES), .VAD_HOLD_CYCLES(A_HOLD),
              .ON_MAX_CYCLES(A_ONMAX), .TIMEOUT_CYCLES(A_TMO), .STAT_W(A_SW)) dutA (
      .clk_i(clk), .rst_i(rst), .vad_i(vadA), .wake_valid_i(wvA),
      .en_o(enA), .busy_o(busyA), .state_o(stateA), .watchdog_o(wdA),
      .wake_cnt_o(wakeCntA), .wdog_cnt_o(wdogCntA));

   ctl_vote #(.N_VAD(B_N), .VAD_VOTES(B_VOTES), .VAD_HOLD_CYCLES(B_HOLD),
              .ON_MAX_CYCLES(B_ONMAX), .TIMEOUT_CYCLES(B_TMO), .STAT_W(B_SW)) dutB (
      .clk_i(clk), .rst_i(rst), .vad_i(vadB), .wake_valid_i(wvB),
      .en_o(enB), .busy_o(busyB), .state_o(stateB), .watchdog_o(wdB),
      .wake_cnt_o(wakeCntB), .wdog_cnt_o(wdogCntB));

   always #5 clk = ~clk;

   // Compare one observed value against its expectation and keep the tally.
   task automatic checkOutput(input string name, input int actual, input int expected);
      assertions++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive one cycle of inputs and return #1 after the edge that samples them.
   task automatic applyStimulus(input logic [A_N-1:0] va, input logic wa,
                                input logic [B_N-1:0] vb, input logic wb, input logic r);
      vadA = va;
      wvA  = wa;
      vadB = vb;
      wvB  = wb;
      rst  = r;
      @(posedge clk);
      #1;
   endtask

   // Behavioural reference: a controller is either waiting (with a streak of
   // consecutive passing votes), enabled for some age, or cooling down.
   task automatic modelStep(input int k, input int votes, input int hold, input int onMax,
                            input int tmo, input int pop, input logic wv, input logic r);
      bit fallSeen;
      mPulse[k] = 1'b0;
      if (r) begin
         mMode[k] = WAITING; mStreak[k] = 0; mOnAge[k] = 0; mToAge[k] = 0;
         mWake[k] = 0; mWdog[k] = 0; mPrevWv[k] = 1'b0;
         return;
      end
      fallSeen   = mPrevWv[k] && !wv;
      mPrevWv[k] = wv;
      if (mMode[k] == WAITING) begin
         if (pop >= votes) begin
            mStreak[k]++;
            if (mStreak[k] >= hold) begin
               mMode[k] = ENABLED; mStreak[k] = 0; mOnAge[k] = 0; mWake[k]++;
            end
         end else begin
            mStreak[k] = 0;
         end
      end else if (mMode[k] == ENABLED) begin
         if (fallSeen) begin
            mMode[k] = COOLING; mToAge[k] = 0;
         end else if (onMax != 0 && mOnAge[k] + 1 == onMax) begin
            mMode[k] = COOLING; mToAge[k] = 0; mPulse[k] = 1'b1; mWdog[k]++;
         end else begin
            mOnAge[k]++;
         end
      end else begin
         mToAge[k]++;
         if (mToAge[k] == tmo) mMode[k] = WAITING;
      end
   endtask

   function automatic int expState(input int k);
      if (mMode[k] == WAITING) return (mStreak[k] > 0) ? 1 : 0;
      if (mMode[k] == ENABLED) return 2;
      return 3;
   endfunction

   function automatic int expStat(input int v, input int w);
`ifdef CTL_VOTE_STATS_EN
      int top = (1 << w) - 1;
      return (v > top) ? top : v;
`else
      return 0 * v * w;
`endif
   endfunction

   always @(posedge clk) begin
      modelStep(0, A_VOTES, A_HOLD, A_ONMAX, A_TMO, $countones(vadA), wvA, rst);
      modelStep(1, B_VOTES, B_HOLD, B_ONMAX, B_TMO, $countones(vadB), wvB, rst);
      if (rst) modelReady = 1'b1;
   end

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (modelReady) begin
         checkOutput("A.state", int'(stateA), expState(0));
         checkOutput("A.en", int'(enA), int'(expState(0) == 2));
         checkOutput("A.busy", int'(busyA), int'(expState(0) != 0));
         checkOutput("A.watchdog", int'(wdA), int'(mPulse[0]));
         checkOutput("A.wakeCnt", int'(wakeCntA), expStat(mWake[0], A_SW));
         checkOutput("A.wdogCnt", int'(wdogCntA), expStat(mWdog[0], A_SW));
         checkOutput("B.state", int'(stateB), expState(1));
         checkOutput("B.en", int'(enB), int'(expState(1) == 2));
         checkOutput("B.busy", int'(busyB), int'(expState(1) != 0));
         checkOutput("B.watchdog", int'(wdB), int'(mPulse[1]));
         checkOutput("B.wakeCnt", int'(wakeCntB), expStat(mWake[1], B_SW));
         checkOutput("B.wdogCnt", int'(wdogCntB), expStat(mWdog[1], B_SW));
      end
   end

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #500000;
      failures++;
      $display("[TB] FAIL simTimeout: got time %0t, expected completion earlier", $time);
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

   initial begin
      int onCycles;
      logic [A_N-1:0] va;
      logic wa, wb, r;
      logic [B_N-1:0] vb;

      applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("lit.resetState", int'(stateA), 0);
      checkOutput("lit.resetEn", int'(enA), 0);

      // Two of four channels never reach the 3-vote threshold.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);
         checkOutput("lit.weakVoteIdle", int'(stateA), 0);
      end

      // Single-cycle pulse arms then drops back.
      applyStimulus(4'b0111, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("lit.pulseArm", int'(stateA), 1);
      applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("lit.pulseIdle", int'(stateA), 0);
      checkOutput("lit.pulseEn", int'(enA), 0);

      // Debounced turn-on, then inference completes.
      applyStimulus(4'b0111, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("lit.debArm", int'(stateA), 1);
      applyStimulus(4'b0111, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("lit.debOn", int'(stateA), 2);
      checkOutput("lit.debEn", int'(enA), 1);
      applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("lit.doneTimeout", int'(stateA), 3);
      checkOutput("lit.doneEn", int'(enA), 0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
         checkOutput("lit.timeoutHold", int'(stateA), 3);
         checkOutput("lit.timeoutBusy", int'(busyA), 1);
      end
      applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("lit.timeoutEnd", int'(stateA), 0);

      // Watchdog: enabled for exactly 8 cycles, then a single pulse.
      applyStimulus(4'b1110, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b1110, 1'b0, 1'b0, 1'b0, 1'b0);
      onCycles = 1;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
         if (!enA) break;
         onCycles++;
      end
      checkOutput("lit.wdogOnCycles", onCycles, 8);
      checkOutput("lit.wdogPulse", int'(wdA), 1);
`ifdef CTL_VOTE_STATS_EN
      checkOutput("lit.wdogCnt", int'(wdogCntA), 1);
`else
      checkOutput("lit.wdogCnt", int'(wdogCntA), 0);
`endif
      applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("lit.wdogPulseEnd", int'(wdA), 0);
      for (int i = 0; i < 4; i++) applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

      // Collision: fall on the final enabled cycle beats the watchdog.
      applyStimulus(4'b1011, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b1011, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("lit.collStillOn", int'(stateA), 2);
      applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("lit.collTimeout", int'(stateA), 3);
      checkOutput("lit.collNoPulse", int'(wdA), 0);
`ifdef CTL_VOTE_STATS_EN
      checkOutput("lit.collWdogCnt", int'(wdogCntA), 1);
      checkOutput("lit.wakeCntSat", int'(wakeCntA), 3);
`else
      checkOutput("lit.collWdogCnt", int'(wdogCntA), 0);
      checkOutput("lit.wakeCntSat", int'(wakeCntA), 0);
`endif
      for (int i = 0; i < 5; i++) applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset in the middle of ON, then in the middle of TIMEOUT.
      applyStimulus(4'b0111, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b0111, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput("lit.rstOnState", int'(stateA), 0);
      checkOutput("lit.rstOnEn", int'(enA), 0);
      checkOutput("lit.rstOnBusy", int'(busyA), 0);
      checkOutput("lit.rstWakeCnt", int'(wakeCntA), 0);
      applyStimulus(4'b0111, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b0111, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("lit.rstToPre", int'(stateA), 3);
      applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("lit.rstToState", int'(stateA), 0);
      checkOutput("lit.rstToBusy", int'(busyA), 0);

      // Randomized traffic on both instances with occasional resets.
      wa = 1'b0;
      wb = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         va = ($urandom_range(0, 2) == 0) ? 4'b1111 : A_N'($urandom_range(0, 15));
         vb = B_N'($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 5) == 0) wa = ~wa;
         if ($urandom_range(0, 3) == 0) wb = ~wb;
         r = ($urandom_range(0, 299) == 0);
         applyStimulus(va, wa, vb, wb, r);
      end

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
